// File: rtl/chan_fifo_if.sv
// Producer/consumer channel bundle for chan_fifo: write side, read side and status.
interface chan_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic signed [WIDTH-1:0] din;
  logic                    we;
  logic signed [WIDTH-1:0] dout;
  logic                    oe;
  logic                    full;
  logic                    empty;
  logic [DEPTH:0]          count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output din, we, oe,
    input  dout, full, empty, count, overflow, underflow
  );

  modport slave (
    input  din, we, oe,
    output dout, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/chan_fifo.sv
// Synchronous channel FIFO, 2**DEPTH x WIDTH, registered read data and sticky
// overflow/underflow flags; full/empty come only from the registered count.
module chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  chan_fifo_if.slave  bus
);
  localparam int             WORDS   = 2**DEPTH;
  localparam logic [DEPTH:0] WORDS_C = (DEPTH+1)'(WORDS);
  localparam logic [DEPTH:0] ONE_C   = (DEPTH+1)'(1);

  logic [WIDTH-1:0]        mem_q [WORDS];
  logic [DEPTH-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH:0]          count_q, count_d;
  logic signed [WIDTH-1:0] dout_q;
  logic                    ovf_q, ovf_d, unf_q, unf_d;
  logic                    full, empty, wr_acc, rd_acc;

  assign full  = (count_q == WORDS_C);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write.
  always_comb begin
    wr_acc  = bus.we && (!full || bus.oe);
    rd_acc  = bus.oe && !empty;
    wp_d    = wr_acc ? wp_q + 1'b1 : wp_q;
    rp_d    = rd_acc ? rp_q + 1'b1 : rp_q;
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (bus.we && !wr_acc);
    unf_d = unf_q | (bus.oe && !rd_acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (rd_acc) dout_q <= mem_q[rp_q];
    end
  end

  // Storage is not reset; pointer reset discards stale entries.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[wp_q] <= bus.din;
  end

  assign bus.dout      = dout_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_chan_fifo.sv
// Randomized and directed bench for chan_fifo against a queue-based FIFO model.
module tb_chan_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  logic [31:0] q[$];
  logic [31:0] m_dout;
  bit          m_ovf, m_unf;

  chan_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Model: a pop frees a slot before the push, reads never succeed when empty.
  task automatic model_edge(input bit we, input logic [31:0] d, input bit oe);
    bit rd_ok, wr_ok;
    rd_ok = oe && (q.size() > 0);
    wr_ok = we && (q.size() < WORDS || rd_ok);
    if (oe && !rd_ok) m_unf = 1'b1;
    if (we && !wr_ok) m_ovf = 1'b1;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
  endtask

  task automatic step(input bit we, input logic [31:0] d, input bit oe);
    bus.we  = we;
    bus.din = d;
    bus.oe  = oe;
    @(posedge clk);
    model_edge(we, d, oe);
    #1;
    bus.we = 1'b0;
    bus.oe = 1'b0;
  endtask

  task automatic hard_reset();
    bus.we = 1'b0;
    bus.oe = 1'b0;
    reset  = 1'b1;
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("count",     32'(bus.count),    32'(q.size()));
      check("full",      32'(bus.full),     32'(q.size() == WORDS));
      check("empty",     32'(bus.empty),    32'(q.size() == 0));
      check("dout",      bus.dout,          m_dout);
      check("overflow",  32'(bus.overflow), 32'(m_ovf));
      check("underflow", 32'(bus.underflow),32'(m_unf));
    end
  end

  initial begin
    logic [31:0] sum;
    int bias_we, bias_oe;
    bus.we = 1'b0; bus.oe = 1'b0; bus.din = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout",  bus.dout,       32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Fill/drain.
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("drain_dout", bus.dout, 32'(i));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_flags", 32'({bus.overflow, bus.underflow}), 32'd0);

    // Wrap-around.
    hard_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 32'(100 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("wrap_dout", bus.dout, 32'(100 + i));
    end

    // Overflow drop.
    hard_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b1, 32'd99, 1'b0);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("ovf_dout", bus.dout, 32'(i));
    end

    // Simultaneous push/pop when full, then when empty.
    hard_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b1, 32'd77, 1'b1);
    check("simf_dout",  bus.dout,         32'd0);
    check("simf_count", 32'(bus.count),   32'd16);
    check("simf_ovf",   32'(bus.overflow),32'd0);
    hard_reset();
    step(1'b1, 32'd5, 1'b1);
    check("sime_unf",   32'(bus.underflow), 32'd1);
    check("sime_count", 32'(bus.count),     32'd1);
    step(1'b0, '0, 1'b1);
    check("sime_dout",  bus.dout, 32'd5);

    // Asynchronous reset between edges.
    hard_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'(11 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    check("pre_rst_dout", bus.dout, 32'd11);
    @(negedge clk);
    #2 reset = 1'b1;
    model_clear();
    #1;
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_dout",  bus.dout,       32'd0);
    #1 reset = 1'b0;
    step(1'b1, 32'd42, 1'b0);
    step(1'b0, '0, 1'b1);
    check("post_rst_dout", bus.dout, 32'd42);

    // Summing producer over 0..15 feeding a single word.
    hard_reset();
    sum = '0;
    for (int i = 0; i < 16; i++) sum = sum + 32'(i);
    step(1'b1, sum, 1'b0);
    step(1'b0, '0, 1'b1);
    check("sys_dout", bus.dout,          32'd120);
    check("sys_full", 32'(bus.full),     32'd0);
    check("sys_ovf",  32'(bus.overflow), 32'd0);

    // Random traffic with shifting bias so both full and empty regions are hit.
    hard_reset();
    for (int blk = 0; blk < 30; blk++) begin
      bias_we = $urandom_range(20, 90);
      bias_oe = $urandom_range(20, 90);
      for (int c = 0; c < 60; c++)
        step($urandom_range(0, 99) < bias_we, $urandom, $urandom_range(0, 99) < bias_oe);
      if (blk % 10 == 9) hard_reset();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
